// File: rtl/pe_acc_f32.sv
// pe_acc_f32 -- sequential FP32 accumulation stage for the PE datapath.
//
// Reduces a stream of FP32 terms into one sum per in_last-terminated group.
// The running sum feeds operand a of a combinational add_f32, the accepted
// term feeds operand b, and the adder's sum is captured back into the
// running-sum register. Results leave over a valid/ready handshake.
//
// Optional feature macro: PE_ACC_FTZ_EN
//   defined   -> terms with exponent field 8'h00 are flushed to +0 before the adder
//   undefined -> terms go to the adder unmodified
//
// Ports (pe_acc_f32):
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous clear, abandons group / pending result
//   in_valid   in   term valid
//   in_ready   out  stage accepts a term this cycle
//   in_data    in   FP32 term
//   in_last    in   final term of the group
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out_data   out  FP32 group sum
//   out_count  out  number of terms in the group (saturating)
//   out_ovf    out  term counter saturated during the group
//
// Ports (add_f32): a, b in FP32 operands; sum out FP32 truncated sum.

`timescale 1ns/1ps

module add_f32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] big_s;
    logic [31:0] small_s;
    logic [7:0]  shift_s;
    logic [23:0] m_big_s;
    logic [23:0] m_al_s;
    logic [24:0] m_sum_s;
    logic [23:0] m_diff_s;
    logic [23:0] m_norm_s;
    logic [7:0]  lz_s;

    // Truncating FP32 add: align the smaller magnitude, add or subtract, renormalise.
    always_comb begin
        if (a[30:0] >= b[30:0]) begin
            big_s   = a;
            small_s = b;
        end else begin
            big_s   = b;
            small_s = a;
        end
        shift_s = big_s[30:23] - small_s[30:23];
        m_big_s = {1'b1, big_s[22:0]};
        if (shift_s > 8'd23) begin
            m_al_s = 24'h000000;
        end else begin
            m_al_s = {1'b1, small_s[22:0]} >> shift_s;
        end
        m_sum_s  = {1'b0, m_big_s} + {1'b0, m_al_s};
        m_diff_s = m_big_s - m_al_s;

        // Leading-zero normalisation of the difference; terminates once bit 23 is set.
        m_norm_s = m_diff_s;
        lz_s     = 8'd0;
        for (int i = 0; i < 23; i++) begin
            if (!m_norm_s[23]) begin
                m_norm_s = m_norm_s << 1;
                lz_s     = lz_s + 8'd1;
            end else begin
                m_norm_s = m_norm_s;
            end
        end

        // A zero operand passes the other through bit-exact.
        if (a[30:0] == 31'd0) begin
            sum = b;
        end else if (b[30:0] == 31'd0) begin
            sum = a;
        end else if (big_s[31] == small_s[31]) begin
            if (m_sum_s[24]) begin
                sum = {big_s[31], big_s[30:23] + 8'd1, m_sum_s[23:1]};
            end else begin
                sum = {big_s[31], big_s[30:23], m_sum_s[22:0]};
            end
        end else if (m_diff_s == 24'h000000) begin
            sum = 32'h00000000;
        end else begin
            sum = {big_s[31], big_s[30:23] - lz_s, m_norm_s[22:0]};
        end
    end
endmodule

module pe_acc_f32 #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic [31:0]           acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
    logic                  out_ovf_q, out_ovf_d;

    logic [31:0]           term_s;
    logic [31:0]           sum_s;
    logic [31:0]           sum_norm_s;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;
    logic                  ovf_inc_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;

`ifdef PE_ACC_FTZ_EN
    // Zero/denormal terms of either sign are flushed to +0.
    assign term_s = (in_data[30:23] == 8'h00) ? 32'h00000000 : in_data;
`else
    assign term_s = in_data;
`endif

    add_f32 u_add (
        .a   (acc_q),
        .b   (term_s),
        .sum (sum_s)
    );

    // -0 is never fed back as operand a.
    assign sum_norm_s = (sum_s == 32'h80000000) ? 32'h00000000 : sum_s;

    // clr blocks acceptance so it can take priority over any transfer.
    assign in_ready   = (state_q != ST_HOLD) && !clr;
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Saturating term counter; an increment attempted at all-ones sets ovf.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
            ovf_inc_s = 1'b1;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
            ovf_inc_s = ovf_q;
        end
    end

    // Next-state and datapath update for the IDLE/ACCUM/HOLD controller.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            state_d     = ST_IDLE;
            acc_d       = 32'h00000000;
            cnt_d       = CNT_ZERO;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (out_xfer_s) begin
                        state_d     = ST_IDLE;
                        acc_d       = 32'h00000000;
                        cnt_d       = CNT_ZERO;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_IDLE, ST_ACCUM: begin
                    if (in_xfer_s) begin
                        acc_d = sum_norm_s;
                        cnt_d = cnt_inc_s;
                        ovf_d = ovf_inc_s;
                        if (in_last) begin
                            state_d     = ST_HOLD;
                            out_valid_d = 1'b1;
                            out_data_d  = sum_norm_s;
                            out_count_d = cnt_inc_s;
                            out_ovf_d   = ovf_inc_s;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    acc_d       = 32'h00000000;
                    cnt_d       = CNT_ZERO;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= 32'h00000000;
            cnt_q       <= CNT_ZERO;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h00000000;
            out_count_q <= CNT_ZERO;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_pe_acc_f32.sv
`timescale 1ns/1ps

module tb_pe_acc_f32;
    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid1;
    logic        in_valid2;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_data1;
    logic [15:0] out_count1;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [31:0] out_data2;
    logic [1:0]  out_count2;

    int n_cmp;
    int n_fail;

    pe_acc_f32 #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_count(out_count1), .out_ovf(out_ovf1)
    );

    pe_acc_f32 #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_count(out_count2), .out_ovf(out_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic sel2, input logic [31:0] d, input logic last);
        if (sel2) begin
            in_valid2 = 1'b1;
        end else begin
            in_valid1 = 1'b1;
        end
        in_data = d;
        in_last = last;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid1); end
        n_cmp++; if (out_data1 !== 32'h00000000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00000000", out_data1); end
        n_cmp++; if (out_count1 !== 16'd0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", out_count1); end
        n_cmp++; if (out_ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf1); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready1); end
    endtask

    task automatic test_three_terms();
        send(1'b0, 32'h3F800000, 1'b0);
        send(1'b0, 32'h40000000, 1'b0);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL sum3_early_valid got=%b exp=0", out_valid1); end
        send(1'b0, 32'h3F000000, 1'b1);
        n_cmp++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL sum3_valid got=%b exp=1", out_valid1); end
        n_cmp++; if (out_data1 !== 32'h40600000) begin n_fail++; $display("FAIL sum3_data got=%h exp=40600000", out_data1); end
        n_cmp++; if (out_count1 !== 16'd3) begin n_fail++; $display("FAIL sum3_count got=%0d exp=3", out_count1); end
        n_cmp++; if (out_ovf1 !== 1'b0) begin n_fail++; $display("FAIL sum3_ovf got=%b exp=0", out_ovf1); end
        n_cmp++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL sum3_in_ready got=%b exp=0", in_ready1); end
        drain();
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL sum3_drained got=%b exp=0", out_valid1); end
    endtask

    task automatic test_single_term();
        send(1'b0, 32'hC0400000, 1'b1);
        n_cmp++; if (out_data1 !== 32'hC0400000) begin n_fail++; $display("FAIL single_data got=%h exp=C0400000", out_data1); end
        n_cmp++; if (out_count1 !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", out_count1); end
        drain();
    endtask

    task automatic test_cancel_hold();
        send(1'b0, 32'h3FC00000, 1'b0);
        send(1'b0, 32'hBFC00000, 1'b1);
        n_cmp++; if (out_data1 !== 32'h00000000) begin n_fail++; $display("FAIL cancel_data got=%h exp=00000000", out_data1); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid1); end
            n_cmp++; if (out_data1 !== 32'h00000000) begin n_fail++; $display("FAIL hold_data cyc=%0d got=%h exp=00000000", i, out_data1); end
            n_cmp++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready1); end
        end
        drain();
        n_cmp++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready1); end
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL release_valid got=%b exp=0", out_valid1); end
    endtask

    task automatic test_clr();
        send(1'b0, 32'h3F800000, 1'b0);
        send(1'b0, 32'h40400000, 1'b0);
        clr = 1'b1;
        in_valid1 = 1'b1;
        in_data   = 32'h3F800000;
        in_last   = 1'b1;
        #1;
        n_cmp++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got=%b exp=0", in_ready1); end
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid1 = 1'b0;
        in_last   = 1'b0;
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b exp=0", out_valid1); end
        send(1'b0, 32'h40000000, 1'b1);
        n_cmp++; if (out_data1 !== 32'h40000000) begin n_fail++; $display("FAIL clr_data got=%h exp=40000000", out_data1); end
        n_cmp++; if (out_count1 !== 16'd1) begin n_fail++; $display("FAIL clr_count got=%0d exp=1", out_count1); end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'h3F800000, 1'b0);
        end
        send(1'b1, 32'h3F800000, 1'b1);
        n_cmp++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL sat_valid got=%b exp=1", out_valid2); end
        n_cmp++; if (out_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count got=%0d exp=3", out_count2); end
        n_cmp++; if (out_ovf2 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", out_ovf2); end
        n_cmp++; if (out_data2 !== 32'h40A00000) begin n_fail++; $display("FAIL sat_data got=%h exp=40A00000", out_data2); end
        drain();
        send(1'b1, 32'h3F800000, 1'b1);
        n_cmp++; if (out_ovf2 !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_cleared got=%b exp=0", out_ovf2); end
        n_cmp++; if (out_count2 !== 2'd1) begin n_fail++; $display("FAIL sat_count_cleared got=%0d exp=1", out_count2); end
        drain();
    endtask

    task automatic test_ftz_and_async_reset();
        // A denormal term leaves 1.0 unchanged whether flushed or aligned away.
        send(1'b0, 32'h3F800000, 1'b0);
        send(1'b0, 32'h00000001, 1'b1);
        n_cmp++; if (out_data1 !== 32'h3F800000) begin n_fail++; $display("FAIL ftz_data got=%h exp=3F800000", out_data1); end
        n_cmp++; if (out_count1 !== 16'd2) begin n_fail++; $display("FAIL ftz_count got=%0d exp=2", out_count1); end
        n_cmp++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL ftz_valid got=%b exp=1", out_valid1); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%b exp=0", out_valid1); end
        n_cmp++; if (out_data1 !== 32'h00000000) begin n_fail++; $display("FAIL async_rst_data got=%h exp=00000000", out_data1); end
        n_cmp++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready got=%b exp=1", in_ready1); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 32'h40000000, 1'b1);
        n_cmp++; if (out_data1 !== 32'h40000000) begin n_fail++; $display("FAIL post_rst_data got=%h exp=40000000", out_data1); end
        drain();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_data   = 32'h00000000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_three_terms();
        test_single_term();
        test_cancel_hold();
        test_clr();
        test_saturation();
        test_ftz_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
